cache_line_refill: RTL and testbench



---
 rtl/cache_line_refill.sv | 126 ++++++++++++
 tb/tb_cache_line_refill.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_refill.sv
// Cache line refill engine: one INCR read burst per miss, each beat written
// straight into data RAM port A on the cycle it is accepted.
module cache_line_refill #(
    parameter int LEN_DATA   = 32,
    parameter int LEN_ADDR   = 10,
    parameter int LINE_WORDS = 8,
    parameter int LEN_PADDR  = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [LEN_PADDR-1:0]                   req_paddr,
    input  logic [LEN_ADDR-$clog2(LINE_WORDS)-1:0] req_index,
    output logic                                   ar_valid,
    input  logic                                   ar_ready,
    output logic [LEN_PADDR-1:0]                   ar_addr,
    output logic [7:0]                             ar_len,
    input  logic                                   r_valid,
    output logic                                   r_ready,
    input  logic [LEN_DATA-1:0]                    r_data,
    input  logic                                   r_last,
    output logic                                   ram_en,
    output logic [LEN_DATA/8-1:0]                  ram_we,
    output logic [LEN_ADDR-1:0]                    ram_addr,
    output logic [LEN_DATA-1:0]                    ram_wdata,
    output logic                                   done,
    output logic                                   err
);

    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * LEN_DATA / 8);
    localparam int LIDX_W = LEN_ADDR - IDX_W;
    localparam int BE_W   = LEN_DATA / 8;

    localparam logic [IDX_W:0]       CNT_FULL = (IDX_W + 1)'(LINE_WORDS);
    localparam logic [7:0]           AR_LEN   = 8'(LINE_WORDS - 1);
    localparam logic [LEN_PADDR-1:0] OFF_MASK = LEN_PADDR'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [IDX_W:0]       cnt, cnt_nxt;
    logic                 mis, mis_nxt;
    logic [LEN_PADDR-1:0] addr_q, addr_nxt;
    logic [LIDX_W-1:0]    line_idx, idx_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            mis      <= 1'b0;
            addr_q   <= '0;
            line_idx <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            mis      <= mis_nxt;
            addr_q   <= addr_nxt;
            line_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mis_nxt   = mis;
        addr_nxt  = addr_q;
        idx_nxt   = line_idx;
        req_ready = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        ram_en    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_nxt  = req_paddr & ~OFF_MASK;
                    idx_nxt   = req_index;
                    cnt_nxt   = '0;
                    mis_nxt   = 1'b0;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = S_DATA;
            end
            S_DATA: begin
                r_ready = 1'b1;
                if (r_valid) begin
                    // Beats beyond a full line are drained but never written.
                    if (cnt < CNT_FULL) begin
                        ram_en  = 1'b1;
                        cnt_nxt = cnt + 1'b1;
                        if (r_last && (cnt_nxt < CNT_FULL)) mis_nxt = 1'b1;
                    end else begin
                        mis_nxt = 1'b1;
                    end
                    if (r_last) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                err       = mis;
                mis_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ram_we    = {BE_W{ram_en}};
    assign ram_addr  = {line_idx, cnt[IDX_W-1:0]};
    assign ram_wdata = r_data;
    assign ar_addr   = addr_q;
    assign ar_len    = AR_LEN;

endmodule

// File: tb/tb_cache_line_refill.sv
// Randomized scoreboard bench for cache_line_refill: the driver pushes the
// expected burst address, RAM writes and done/err; a negedge monitor pops them.
module tb_cache_line_refill;

    localparam int LW = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_paddr = '0;
    logic [6:0]  req_index = '0;
    logic        ar_valid;
    logic        ar_ready = 1'b0;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [31:0] r_data = '0;
    logic        r_last = 1'b0;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        done;
    logic        err;

    cache_line_refill #(
        .LEN_DATA(32), .LEN_ADDR(10), .LINE_WORDS(LW), .LEN_PADDR(32)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_paddr(req_paddr), .req_index(req_index),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .ar_addr(ar_addr), .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready),
        .r_data(r_data), .r_last(r_last),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] aq[$];
    bit          dq[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    wr_t mw;
    always @(negedge clk) begin
        if (ram_en) begin
            chk("wr_on_handshake", {63'd0, r_valid && r_ready}, 64'd1);
            if (wq.size() == 0) fail_now("ram_wr_extra");
            else begin
                mw = wq.pop_front();
                chk("ram_addr", {54'd0, ram_addr}, {54'd0, mw.a});
                chk("ram_wdata", {32'd0, ram_wdata}, {32'd0, mw.d});
                chk("ram_we", {60'd0, ram_we}, 64'hF);
            end
        end else if (r_valid) begin
            chk("ram_we_idle", {60'd0, ram_we}, 64'd0);
        end
        if (ar_valid) begin
            if (aq.size() == 0) fail_now("ar_extra");
            else begin
                chk("ar_addr", {32'd0, ar_addr}, {32'd0, aq[0]});
                chk("ar_len", {56'd0, ar_len}, LW - 1);
                if (ar_ready) void'(aq.pop_front());
            end
        end
        if (err && !done) fail_now("err_without_done");
        if (done) begin
            if (dq.size() == 0) fail_now("done_extra");
            else chk("done_err", {63'd0, err}, {63'd0, dq.pop_front()});
        end
    end

    // mode: 0 r_valid always, 1 pattern 1,0,0, 2 random. abort>0 resets after that many beats.
    task automatic do_refill(input logic [31:0] paddr, input int idx, input int nbeats,
                             input int ar_delay, input int mode, input bit data_rnd,
                             input int abort, input bit chk_b2b, input bit chk_lat);
        logic [31:0] d[16];
        int k, ard, n, p, c0, guard, nwr;
        bit v, acc;
        for (int i = 0; i < nbeats; i++) d[i] = data_rnd ? $urandom : 32'hA0 + 32'(i);
        // Reference model: line-aligned address, word i of line idx gets beat i.
        aq.push_back(paddr - (paddr % (LW * 4)));
        nwr = (nbeats < LW) ? nbeats : LW;
        if (abort > 0) nwr = abort;
        for (int i = 0; i < nwr; i++) wq.push_back('{a: 10'(idx * LW + i), d: d[i]});
        if (abort == 0) dq.push_back(nbeats != LW);

        req_valid = 1'b1;
        req_paddr = paddr;
        req_index = 7'(idx);
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (chk_b2b) chk("b2b_accept_wait", 64'(n), 64'd1);
        step();
        c0 = cyc;
        req_valid = 1'b0;
        req_paddr = $urandom;
        req_index = 7'($urandom);

        k = 0; ard = ar_delay; p = 0; guard = 0;
        while (k < nbeats && guard < 500) begin
            ar_ready = ar_valid && (ard == 0);
            if (ar_valid && ard > 0) ard--;
            case (mode)
                0: v = 1'b1;
                1: v = (p % 3) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            p++;
            r_valid = v;
            r_data  = v ? d[k] : $urandom;
            r_last  = v && (k == nbeats - 1);
            acc = v && r_ready;
            step();
            guard++;
            if (acc) k++;
            if (abort > 0 && k == abort) break;
        end
        if (guard >= 500) fail_now("burst_timeout");
        ar_ready = 1'b0;

        if (abort > 0) begin
            r_valid = 1'b1;
            r_data  = $urandom;
            #3 resetn = 1'b0;
            #1;
            chk("rst_ram_en", {63'd0, ram_en}, 64'd0);
            chk("rst_r_ready", {63'd0, r_ready}, 64'd0);
            chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
            chk("rst_done", {63'd0, done}, 64'd0);
            r_valid = 1'b0;
            step();
            step();
            #2 resetn = 1'b1;
            step();
            chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        end else begin
            r_valid = 1'b0;
            r_last  = 1'b0;
            chk("done_after_last", {63'd0, done}, 64'd1);
            chk("err_with_done", {63'd0, err}, {63'd0, nbeats != LW});
            if (chk_lat) chk("done_latency", 64'(cyc - c0), LW + 1);
        end
    endtask

    initial begin
        #1;
        chk("reset_ar_valid", {63'd0, ar_valid}, 64'd0);
        chk("reset_r_ready", {63'd0, r_ready}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_ram_en", {63'd0, ram_en}, 64'd0);
        step();
        step();
        #2 resetn = 1'b1;
        step();
        chk("reset_req_ready", {63'd0, req_ready}, 64'd1);

        do_refill(32'h1000_0034, 5, LW, 0, 0, 1'b0, 0, 1'b0, 1'b1);
        do_refill(32'h1000_0034, 5, LW, 3, 1, 1'b0, 0, 1'b1, 1'b0);
        do_refill(32'h2000_0100, 5, 3, 1, 0, 1'b1, 0, 1'b1, 1'b0);
        do_refill(32'h3000_00FC, 5, 10, 0, 0, 1'b1, 0, 1'b1, 1'b0);
        do_refill(32'h4000_0000, 9, LW, 0, 0, 1'b1, 4, 1'b0, 1'b0);
        do_refill(32'h5000_0040, 0, LW, 0, 0, 1'b1, 0, 1'b0, 1'b1);
        do_refill(32'h6000_1FE0, 127, LW, 2, 2, 1'b1, 0, 1'b1, 1'b0);
        do_refill(32'h7000_0020, 3, LW, 0, 0, 1'b1, 0, 1'b1, 1'b1);
        for (int t = 0; t < 12; t++) begin
            int nb;
            nb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 10) : LW;
            do_refill($urandom, $urandom_range(0, 127), nb, $urandom_range(0, 4),
                      $urandom_range(0, 2), 1'b1, 0, 1'b1, 1'b0);
        end
        step();
        step();
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("aq_drained", 64'(aq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
